// File: rtl/wei_dist.sv
// ============================================================================
//  Module      : wei_dist
//  Description : Weight distributor. Prefetches weight words from the global
//                buffer (GBF) into a small FIFO and hands them to the PE
//                cluster in blocks of BLK_LEN words on controller request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wei_dist #(
  parameter int WEI_W   = 64,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 8,
  parameter int BLK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Reset,
  input  logic              CTRLWEI_PlsFetch,
  output logic              DISWEI_RdyFIFO,
  output logic              DISWEIGBF_Rd,
  output logic [ADDR_W-1:0] DISWEIGBF_Addr,
  input  logic              GBFDISWEI_Rdy,
  input  logic              GBFDISWEI_Val,
  input  logic [WEI_W-1:0]  GBFDISWEI_Dat,
  output logic              DISWEIPEC_Val,
  output logic [WEI_W-1:0]  DISWEIPEC_Dat,
  output logic              DISWEIPEC_Last,
  input  logic              PECDISWEI_Rdy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              rdy_q;
  logic [WEI_W-1:0]  fifo_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_q;     // a read was accepted last cycle; data due now
  logic [ADDR_W-1:0] addr_q;
  logic [WC_W-1:0]   wcnt_q;
  logic              disc_q;     // drop the GBF return that trails a soft abort

  logic w_clr, w_rd, w_rd_acc, w_push, w_val, w_last, w_pop;

  // Hard and soft reset share the same clearing behaviour
  assign w_clr    = rst | Reset;
  // Issue a read only while the FIFO plus in-flight data still has room
  assign w_rd     = (state_q != S_IDLE) && ((cnt_q + CNT_W'(pend_q)) < CNT_W'(DEPTH));
  assign w_rd_acc = w_rd & GBFDISWEI_Rdy;
  assign w_push   = GBFDISWEI_Val & ~disc_q & (state_q != S_IDLE);
  assign w_val    = (state_q == S_SEND) && (cnt_q != '0);
  assign w_last   = (wcnt_q == WC_W'(BLK_LEN - 1));
  assign w_pop    = w_val & PECDISWEI_Rdy;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (w_clr) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      disc_q  <= Reset & ~rst;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == S_READY);
      if (w_push) wptr_q <= wptr_q + PTR_W'(1);
      if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q   <= cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);
      pend_q  <= w_rd_acc;
      if (state_q == S_IDLE && Start) addr_q <= '0;
      else if (w_rd_acc)              addr_q <= addr_q + ADDR_W'(1);
      if (w_pop) wcnt_q <= w_last ? '0 : wcnt_q + WC_W'(1);
      disc_q  <= 1'b0;
    end
  end

  // FIFO storage: returned GBF words are written at the tail
  always_ff @(posedge clk) begin
    if (!w_clr && w_push) fifo_q[wptr_q] <= GBFDISWEI_Dat;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start)                          state_d = S_FILL;
      S_FILL:  if (cnt_q >= CNT_W'(BLK_LEN))       state_d = S_READY;
      S_READY: if (CTRLWEI_PlsFetch)               state_d = S_SEND;
      S_SEND:  if (w_pop && w_last)                state_d = S_FILL;
      default:                                     state_d = S_IDLE;
    endcase
  end

  // Output decode; data is forced to zero whenever it is not valid
  always_comb begin
    DISWEIGBF_Rd   = w_rd;
    DISWEIPEC_Val  = w_val;
    DISWEIPEC_Last = w_val & w_last;
    DISWEIPEC_Dat  = w_val ? fifo_q[rptr_q] : '0;
  end

  assign DISWEI_RdyFIFO = rdy_q;
  assign DISWEIGBF_Addr = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_wei_dist.sv
// ============================================================================
//  Module      : tb_wei_dist
//  Description : Self-checking bench for wei_dist: directed vector table,
//                hand-written abort sequence and randomized traffic, all
//                checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wei_dist;

  localparam int WEI_W   = 64;
  localparam int AW      = 3;
  localparam int DEPTH   = 8;
  localparam int BLK_LEN = 4;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_READY = 2;
  localparam int M_SEND  = 3;

  logic             clk = 1'b0;
  logic             rst, start, sreset, pls;
  logic             gbf_rdy, gbf_val, pec_rdy;
  logic [WEI_W-1:0] gbf_dat;
  logic             rdyfifo, gbf_rd, pec_val, pec_last;
  logic [AW-1:0]    gbf_addr;
  logic [WEI_W-1:0] pec_dat;

  always #5 clk = ~clk;

  wei_dist #(.WEI_W(WEI_W), .ADDR_W(AW), .DEPTH(DEPTH), .BLK_LEN(BLK_LEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .Start            (start),
    .Reset            (sreset),
    .CTRLWEI_PlsFetch (pls),
    .DISWEI_RdyFIFO   (rdyfifo),
    .DISWEIGBF_Rd     (gbf_rd),
    .DISWEIGBF_Addr   (gbf_addr),
    .GBFDISWEI_Rdy    (gbf_rdy),
    .GBFDISWEI_Val    (gbf_val),
    .GBFDISWEI_Dat    (gbf_dat),
    .DISWEIPEC_Val    (pec_val),
    .DISWEIPEC_Dat    (pec_dat),
    .DISWEIPEC_Last   (pec_last),
    .PECDISWEI_Rdy    (pec_rdy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, buffered words, in-flight read, address, word index
  int               m_state = M_IDLE;
  logic [WEI_W-1:0] m_q[$];
  bit               m_out   = 1'b0;
  int               m_addr  = 0;
  int               m_wcnt  = 0;
  bit               m_disc  = 1'b0;
  bit               env_acc = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  task automatic step(input bit hr, input bit st, input bit rs, input bit pl,
                      input bit gr, input bit pr);
    bit e_rdy, e_rd, e_val, e_last, push, acc, pop, fill_ok, acc_env;
    rst     = hr;
    start   = st;
    sreset  = rs;
    pls     = pl;
    gbf_rdy = gr;
    pec_rdy = pr;
    gbf_val = env_acc;
    gbf_dat = {$urandom(), $urandom()};
    #1;
    e_rdy  = (m_state == M_READY);
    e_rd   = (m_state != M_IDLE) && ((m_q.size() + int'(m_out)) < DEPTH);
    e_val  = (m_state == M_SEND) && (m_q.size() > 0);
    e_last = e_val && (m_wcnt == BLK_LEN - 1);
    chk("RdyFIFO", 64'(rdyfifo), 64'(e_rdy));
    chk("GBF_Rd", 64'(gbf_rd), 64'(e_rd));
    if (e_rd)  chk("GBF_Addr", 64'(gbf_addr), 64'(m_addr));
    chk("PEC_Val", 64'(pec_val), 64'(e_val));
    chk("PEC_Last", 64'(pec_last), 64'(e_last));
    if (e_val) chk("PEC_Dat", pec_dat, m_q[0]);
    acc_env = gbf_rd && gr;

    if (hr || rs) begin
      m_state = M_IDLE;
      m_q.delete();
      m_out   = 1'b0;
      m_addr  = 0;
      m_wcnt  = 0;
      m_disc  = !hr;
    end else begin
      push    = gbf_val && !m_disc && (m_state != M_IDLE);
      acc     = e_rd && gr;
      pop     = e_val && pr;
      fill_ok = (m_q.size() >= BLK_LEN);
      if (push) chk("no_overflow", 64'(m_q.size() - int'(pop) < DEPTH), 64'(1));
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(gbf_dat);
      if (acc)  m_addr = (m_addr + 1) % (1 << AW);
      if (pop)  m_wcnt = e_last ? 0 : m_wcnt + 1;
      case (m_state)
        M_IDLE:  if (st) begin m_state = M_FILL; m_addr = 0; end
        M_FILL:  if (fill_ok) m_state = M_READY;
        M_READY: if (pl) m_state = M_SEND;
        default: if (pop && e_last) m_state = M_FILL;
      endcase
      m_out  = acc;
      m_disc = 1'b0;
    end
    @(posedge clk);
    env_acc = acc_env;
    @(negedge clk);
  endtask

  typedef struct {
    bit hr, st, rs, pl, gr, pr;
    int ncyc;
    int exp_rdy;   // RdyFIFO after the segment, -1 = not checked
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; start = 1'b0; sreset = 1'b0; pls = 1'b0;
    gbf_rdy = 1'b0; gbf_val = 1'b0; pec_rdy = 1'b0; gbf_dat = '0;

    //                hr st rs pl gr pr  n  rdy
    tbl.push_back('{1, 0, 0, 0, 1, 1,  2,  0});  // reset state
    tbl.push_back('{0, 0, 0, 0, 1, 1,  3,  0});  // idle without Start
    tbl.push_back('{0, 1, 0, 0, 1, 1,  1,  0});  // Start -> FILL
    tbl.push_back('{0, 0, 0, 0, 1, 1,  3,  0});  // still filling
    tbl.push_back('{0, 0, 0, 1, 1, 1,  1, -1});  // spurious PlsFetch in FILL
    tbl.push_back('{0, 0, 0, 0, 1, 1,  6,  1});  // block buffered
    tbl.push_back('{0, 1, 0, 0, 1, 1,  1,  1});  // spurious Start in READY
    tbl.push_back('{0, 0, 0, 1, 1, 1,  1,  0});  // claim -> SEND
    tbl.push_back('{0, 0, 0, 0, 1, 1, 10,  1});  // 4 words, next block ready
    tbl.push_back('{1, 0, 0, 0, 1, 1,  1,  0});  // hard reset
    tbl.push_back('{0, 1, 0, 0, 0, 1,  1,  0});  // Start with GBF stalled
    tbl.push_back('{0, 0, 0, 0, 0, 1, 10,  0});  // 10-cycle GBF stall
    tbl.push_back('{0, 0, 0, 0, 1, 1,  8,  1});  // resumes, block ready
    tbl.push_back('{0, 0, 0, 1, 1, 0,  1,  0});  // claim with PEC stalled
    tbl.push_back('{0, 0, 0, 0, 1, 1,  1, -1});  // word 1
    tbl.push_back('{0, 0, 0, 1, 1, 0,  2, -1});  // stall + spurious pulse
    tbl.push_back('{0, 0, 0, 0, 1, 1,  2, -1});  // words 2,3
    tbl.push_back('{0, 0, 0, 0, 1, 0,  2, -1});  // stall
    tbl.push_back('{0, 0, 0, 0, 1, 1,  1,  0});  // word 4 -> FILL
    tbl.push_back('{0, 0, 0, 0, 1, 1,  1,  1});  // READY one cycle later

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].ncyc; c++)
        step(tbl[i].hr, tbl[i].st, tbl[i].rs, tbl[i].pl, tbl[i].gr, tbl[i].pr);
      #1;
      if (tbl[i].exp_rdy >= 0)
        chk($sformatf("tbl%0d_RdyFIFO", i), 64'(rdyfifo), 64'(tbl[i].exp_rdy));
    end

    // Abort mid-SEND after word 2 with a read in flight
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("abort_rd_pending", 64'(gbf_rd), 64'(1));
    step(0, 0, 1, 0, 1, 1);
    #1;
    chk("abort_Val", 64'(pec_val), 64'(0));
    chk("abort_Rd", 64'(gbf_rd), 64'(0));
    chk("abort_RdyFIFO", 64'(rdyfifo), 64'(0));
    step(0, 0, 0, 0, 1, 1);            // late GBF data arrives here
    step(0, 1, 0, 0, 1, 1);
    #1;
    chk("restart_Rd", 64'(gbf_rd), 64'(1));
    chk("restart_Addr", 64'(gbf_addr), 64'(0));
    for (int c = 0; c < 12; c++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(499) == 0, $urandom_range(7) == 0, $urandom_range(99) == 0,
           $urandom_range(3) == 0, $urandom_range(3) != 0, $urandom_range(2) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wei_dist.md
WEI_DIST -- requirements
Module: wei_dist

Interface
REQ-001 Parameters (name, default, meaning):
- WEI_W, 64, weight word width.
- ADDR_W, 12, GBF weight address width.
- DEPTH, 8, internal FIFO depth in words (power of 2, >= 2*BLK_LEN).
- BLK_LEN, 4, words per PEC weight block.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- Start, in, 1, begin prefetching from address 0.
- Reset, in, 1, soft abort of the current configuration pass.
- CTRLWEI_PlsFetch, in, 1, one-cycle pulse from the controller; claims the buffered block.
- DISWEI_RdyFIFO, out, 1, a full block is buffered and claimable.
- DISWEIGBF_Rd, out, 1, GBF read request.
- DISWEIGBF_Addr, out, ADDR_W, GBF read address.
- GBFDISWEI_Rdy, in, 1, GBF accepts a read this cycle.
- GBFDISWEI_Val, in, 1, read data valid.
- GBFDISWEI_Dat, in, WEI_W, read data.
- DISWEIPEC_Val, out, 1, weight word valid to PEC.
- DISWEIPEC_Dat, out, WEI_W, weight word.
- DISWEIPEC_Last, out, 1, marks the final word of a block.
- PECDISWEI_Rdy, in, 1, PEC accepts a word.

Function
REQ-003 The block SHALL implement FSM states IDLE, FILL, READY and SEND.
REQ-004 FSM transitions SHALL be:
- IDLE->FILL on Start.
- FILL->READY when FIFO count >= BLK_LEN.
- READY->SEND on CTRLWEI_PlsFetch.
- SEND->FILL on handshake of word BLK_LEN.
REQ-005 DISWEI_RdyFIFO SHALL equal (state==READY), registered, with no combinational path from any input.
REQ-006 CTRLWEI_PlsFetch SHALL be ignored in IDLE, FILL and SEND.
REQ-007 A GBF read SHALL occur on a cycle where DISWEIGBF_Rd and GBFDISWEI_Rdy are both 1; the Rd assertion rule is given in REQ-008.
REQ-008 DISWEIGBF_Rd SHALL be asserted in any non-IDLE state whenever (FIFO count + outstanding reads) < DEPTH.
REQ-009 GBF data SHALL return on GBFDISWEI_Val exactly 1 cycle after the accepted read; at most 1 read is outstanding per cycle of latency.
REQ-010 DISWEIGBF_Addr SHALL increment by 1 per accepted read and wrap from 2^ADDR_W-1 to 0.
REQ-011 Start SHALL load the address with 0.
REQ-012 Returned data SHALL be written to the FIFO tail.
REQ-013 The FIFO SHALL never overflow; GBFDISWEI_Val with the FIFO full is prevented by REQ-008.
REQ-014 In SEND, DISWEIPEC_Val SHALL be 1 while the FIFO is non-empty, and DISWEIPEC_Dat SHALL be the FIFO head.
REQ-015 A PEC word SHALL transfer when DISWEIPEC_Val and PECDISWEI_Rdy are both 1; the FIFO head then pops and the word counter increments.
REQ-016 DISWEIPEC_Last SHALL be 1 with Val when the word counter equals BLK_LEN-1.
REQ-017 On the last handshake the word counter SHALL clear to 0.
REQ-018 A simultaneous FIFO push and pop SHALL leave the count unchanged.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH.
REQ-020 DISWEIPEC_Dat SHALL be held stable while Val=1 and Rdy=0.
REQ-021 Prefetch SHALL continue during SEND so that the next block can be READY in the cycle after SEND exits.
REQ-022 Reset (soft) SHALL, in the next cycle:
- move the FSM to IDLE;
- flush the FIFO and clear the word counter and address;
- drop Val and Rd.
REQ-023 A GBFDISWEI_Val arriving in the cycle after Reset SHALL be discarded.
REQ-024 Reset SHALL take priority over Start, CTRLWEI_PlsFetch and any handshake in the same cycle.
REQ-025 Start SHALL be ignored outside IDLE.

Reset
REQ-026 rst SHALL produce the same state as soft Reset in the next cycle: state=IDLE, all outputs 0, count=0, pointers=0, address=0, discard flag cleared.
REQ-027 rst SHALL take priority over every other input.

Verification
REQ-028 Fill and claim: Start with GBF Rdy=1 and PEC Rdy=1 (BLK_LEN=4) -> Rd at addresses 0..7; RdyFIFO rises once count reaches 4; a PlsFetch then yields 4 words in consecutive cycles with Last on the 4th; RdyFIFO returns 1 cycle after SEND exits.
REQ-029 PEC backpressure: PECDISWEI_Rdy toggles 1,0,0,1 -> Dat held across stalls; exactly 4 transfers per block; count never exceeds 8; Rd pauses when count+outstanding reaches 8.
REQ-030 GBF stall: GBFDISWEI_Rdy=0 for 10 cycles during FILL -> Addr frozen, RdyFIFO stays 0, and progress resumes with no skipped addresses.
REQ-031 Address wrap: ADDR_W=3, 3 blocks -> address sequence 0..7, 0..3, and data order preserved.
REQ-032 Abort: Reset mid-SEND after word 2, with a read outstanding -> next cycle Val=0, Rd=0, RdyFIFO=0; the late GBF data is discarded; a fresh Start refetches from address 0.
REQ-033 Spurious pulses: PlsFetch in FILL or SEND, and Start in READY -> no state change and no extra transfers.
